// File: rtl/prbs31_checker.sv
// Serial PRBS31 (x^31 + x^28 + 1) checker: self-syncs, locks, then counts errors against a free-running reference.
// Lock on the edge of valid bit 31+LOCK_CNT; err_flag/locked registered (1 cycle); din_valid low freezes all state.
module prbs31_checker #(
  parameter int LOCK_CNT  = 64,
  parameter int LOSS_ERRS = 8,
  parameter int LOSS_WIN  = 256,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(LOSS_WIN + 1);
  localparam int EW = $clog2(LOSS_ERRS + 1);

  localparam logic [4:0]    FILL_LAST  = 5'd30;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(LOSS_WIN - 1);
  localparam logic [EW-1:0] ERRS_LAST  = EW'(LOSS_ERRS - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [30:0]      r_rx;
  logic [30:0]      r_ref;
  logic [4:0]       r_fill_cnt;
  logic [MW-1:0]    r_match_cnt;
  logic [WW-1:0]    r_win_bits;
  logic [EW-1:0]    r_win_errs;
  logic [ERR_W-1:0] r_err_count;
  logic             r_locked;
  logic             r_err_flag;

  logic [30:0]      w_rx_nxt;
  logic [30:0]      w_ref_nxt;
  logic [4:0]       w_fill_nxt;
  logic [MW-1:0]    w_match_nxt;
  logic [WW-1:0]    w_win_bits_nxt;
  logic [EW-1:0]    w_win_errs_nxt;
  logic [ERR_W-1:0] w_err_cnt_nxt;
  logic             w_pred;
  logic             w_match;
  logic             w_ref_pred;
  logic             w_err_bit;

  assign w_rx_nxt   = {r_rx[29:0], din};
  assign w_pred     = r_rx[27] ^ r_rx[30];
  // An all-zero history is the stuck-at-0 signature; it must never count as a match.
  assign w_match    = (din == w_pred) && (r_rx != 31'd0);
  assign w_ref_pred = r_ref[27] ^ r_ref[30];

  always_comb begin
    w_state_nxt    = r_state;
    w_fill_nxt     = r_fill_cnt;
    w_match_nxt    = r_match_cnt;
    w_win_bits_nxt = r_win_bits;
    w_win_errs_nxt = r_win_errs;
    w_ref_nxt      = r_ref;
    w_err_bit      = 1'b0;
    if (din_valid) begin
      case (r_state)
        S_FILL: begin
          if (r_fill_cnt == FILL_LAST) begin
            w_state_nxt = S_VERIFY;
            w_fill_nxt  = 5'd0;
            w_match_nxt = '0;
          end else begin
            w_fill_nxt = r_fill_cnt + 5'd1;
          end
        end
        S_VERIFY: begin
          if (w_match) begin
            if (r_match_cnt == MATCH_LAST) begin
              w_state_nxt    = S_LOCKED;
              w_match_nxt    = '0;
              w_ref_nxt      = w_rx_nxt;
              w_win_bits_nxt = '0;
              w_win_errs_nxt = '0;
            end else begin
              w_match_nxt = r_match_cnt + MW'(1);
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        S_LOCKED: begin
          // Reference free-runs on its own feedback so one line error is counted once.
          w_ref_nxt = {r_ref[29:0], w_ref_pred};
          w_err_bit = din ^ w_ref_pred;
          if (w_err_bit && (r_win_errs == ERRS_LAST)) begin
            w_state_nxt    = S_FILL;
            w_fill_nxt     = 5'd0;
            w_win_bits_nxt = '0;
            w_win_errs_nxt = '0;
          end else if (r_win_bits == WIN_LAST) begin
            w_win_bits_nxt = '0;
            w_win_errs_nxt = '0;
          end else begin
            w_win_bits_nxt = r_win_bits + WW'(1);
            w_win_errs_nxt = r_win_errs + EW'(w_err_bit);
          end
        end
        default: begin
          w_state_nxt = S_FILL;
          w_fill_nxt  = 5'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_err_cnt_nxt = r_err_count;
    if (clr) begin
      w_err_cnt_nxt = '0;
    end else if (w_err_bit && !(&r_err_count)) begin
      w_err_cnt_nxt = r_err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx        <= 31'd0;
      r_ref       <= 31'd0;
      r_fill_cnt  <= 5'd0;
      r_match_cnt <= '0;
      r_win_bits  <= '0;
      r_win_errs  <= '0;
      r_err_count <= '0;
      r_locked    <= 1'b0;
      r_err_flag  <= 1'b0;
    end else begin
      if (din_valid) begin
        r_rx <= w_rx_nxt;
      end
      r_ref       <= w_ref_nxt;
      r_fill_cnt  <= w_fill_nxt;
      r_match_cnt <= w_match_nxt;
      r_win_bits  <= w_win_bits_nxt;
      r_win_errs  <= w_win_errs_nxt;
      r_err_count <= w_err_cnt_nxt;
      r_locked    <= (w_state_nxt == S_LOCKED);
      r_err_flag  <= w_err_bit;
    end
  end

  assign locked    = r_locked;
  assign err_flag  = r_err_flag;
  assign err_count = r_err_count;
  assign state     = r_state;

endmodule
